// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_t  FSM state encoding (IDLE, BUSY, RESP)
//   PORT_FETCH   requester index of the fetch unit (0)
//   PORT_EXE     requester index of the exe MMU (1)
//   CNT_W        width of the BUSY-cycle timeout counter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_EXE   = 1'b1;
   localparam int   CNT_W      = 8;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of requester and memory-port signals around the arbiter.
//   Requester side : req_valid_x, addr_x, we_x, wrt_data_x (in), grant_x,
//                    data_valid_x, rd_data, err (out)
//   Memory side    : mem_req, mem_addr, mem_we, mem_wrt_data (out),
//                    mem_ack, mem_rd_data (in)
//   modport slave  : the arbiter
//   modport master : the requesters plus the memory (environment side)
interface mem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid_0, req_valid_1;
   logic [ADDR_W-1:0] addr_0, addr_1;
   logic              we_0, we_1;
   logic [DATA_W-1:0] wrt_data_0, wrt_data_1;
   logic              grant_0, grant_1;
   logic              data_valid_0, data_valid_1;
   logic [DATA_W-1:0] rd_data;
   logic              err;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wrt_data;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rd_data;

   modport slave (
      input  req_valid_0, req_valid_1, addr_0, addr_1, we_0, we_1,
             wrt_data_0, wrt_data_1, mem_ack, mem_rd_data,
      output grant_0, grant_1, data_valid_0, data_valid_1, rd_data, err,
             mem_req, mem_addr, mem_we, mem_wrt_data
   );

   modport master (
      output req_valid_0, req_valid_1, addr_0, addr_1, we_0, we_1,
             wrt_data_0, wrt_data_1, mem_ack, mem_rd_data,
      input  grant_0, grant_1, data_valid_0, data_valid_1, rd_data, err,
             mem_req, mem_addr, mem_we, mem_wrt_data
   );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: owner selection for the two-port arbiter.
//   req_0/req_1 in  : pending requests (fetch / exe)
//   owner       out : winning port, valid whenever a request is pending
// Build option MEM_ARB_ROUND_ROBIN_EN: ties go to the port that did not win
// last time (last_owner flop, reset to PORT_EXE); clk, reset and take exist
// only in that build. Without it port 1 (exe) always wins ties.
module mem_arb_pick
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset,
   input  logic take,     // IDLE->BUSY this cycle: commit owner as last_owner
`endif
   input  logic req_0,
   input  logic req_1,
   output logic owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_owner;

   always_ff @(posedge clk) begin
      if (reset)     last_owner <= PORT_EXE;
      else if (take) last_owner <= owner;
   end

   always_comb begin
      owner = PORT_EXE;
      if (req_0 && req_1) owner = ~last_owner;
      else if (req_0)     owner = PORT_FETCH;
   end
`else
   always_comb begin
      owner = req_1 ? PORT_EXE : PORT_FETCH;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch (port 0) and exe MMU (port 1) onto a single
// memory port. One transaction at a time: IDLE -> BUSY -> RESP -> IDLE.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arb_if.slave (requests, grants, completions, memory port)
// Parameters: ADDR_W, DATA_W, TIMEOUT (BUSY cycles allowed before err, 1..255).
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (see mem_arb_pick). All outputs are registered.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic     clk,
   input  logic     reset,
   mem_arb_if.slave bus
);

   arb_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              owner_q, owner_nxt, pick;
   logic [1:0]        grant_q, grant_nxt, dv_q, dv_nxt;
   logic              err_q, err_nxt;
   logic              mem_req_q, mem_req_nxt, mem_we_q, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
   logic [DATA_W-1:0] mem_wd_q, mem_wd_nxt, rd_q, rd_nxt;
   logic              any_req, take, timeout;

   assign any_req = bus.req_valid_0 | bus.req_valid_1;
   assign take    = (state == IDLE) && any_req;
   // cnt counts completed BUSY cycles, so this is the last allowed one
   assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

   mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .clk   (clk),
      .reset (reset),
      .take  (take),
`endif
      .req_0 (bus.req_valid_0),
      .req_1 (bus.req_valid_1),
      .owner (pick)
   );

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         owner_q    <= PORT_FETCH;
         grant_q    <= '0;
         dv_q       <= '0;
         err_q      <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= {ADDR_W{1'b0}};
         mem_wd_q   <= {DATA_W{1'b0}};
         rd_q       <= {DATA_W{1'b0}};
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         owner_q    <= owner_nxt;
         grant_q    <= grant_nxt;
         dv_q       <= dv_nxt;
         err_q      <= err_nxt;
         mem_req_q  <= mem_req_nxt;
         mem_we_q   <= mem_we_nxt;
         mem_addr_q <= mem_addr_nxt;
         mem_wd_q   <= mem_wd_nxt;
         rd_q       <= rd_nxt;
      end
   end

   // next state; mem_ack is only looked at in BUSY, and beats timeout there
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (bus.mem_ack || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // next values of the registered outputs; pulses default low, the latched
   // request fields and rd_data hold between transactions
   always_comb begin
      cnt_nxt      = cnt;
      owner_nxt    = owner_q;
      grant_nxt    = '0;
      dv_nxt       = '0;
      err_nxt      = 1'b0;
      mem_req_nxt  = 1'b0;
      mem_we_nxt   = mem_we_q;
      mem_addr_nxt = mem_addr_q;
      mem_wd_nxt   = mem_wd_q;
      rd_nxt       = rd_q;
      case (state)
         IDLE: if (take) begin
            owner_nxt       = pick;
            grant_nxt[pick] = 1'b1;
            mem_req_nxt     = 1'b1;
            cnt_nxt         = '0;
            mem_addr_nxt    = pick ? bus.addr_1     : bus.addr_0;
            mem_we_nxt      = pick ? bus.we_1       : bus.we_0;
            mem_wd_nxt      = pick ? bus.wrt_data_1 : bus.wrt_data_0;
         end
         BUSY: begin
            if (bus.mem_ack) begin
               dv_nxt[owner_q] = 1'b1;
               rd_nxt          = mem_we_q ? {DATA_W{1'b0}} : bus.mem_rd_data;
            end else if (timeout) begin
               dv_nxt[owner_q] = 1'b1;
               err_nxt         = 1'b1;
               rd_nxt          = {DATA_W{1'b0}};
            end else begin
               mem_req_nxt = 1'b1;
               cnt_nxt     = cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.grant_0      = grant_q[0];
   assign bus.grant_1      = grant_q[1];
   assign bus.data_valid_0 = dv_q[0];
   assign bus.data_valid_1 = dv_q[1];
   assign bus.err          = err_q;
   assign bus.rd_data      = rd_q;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wrt_data = mem_wd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by a randomized phase. The
// reference model works per transaction: when a request is picked at cycle c,
// grant is at g=c+1, the chosen ack delay d gives data_valid at
// g+min(d+1,TIMEOUT) with err when no ack arrives in the window, and the
// arbiter is free again one cycle after data_valid.
module tb_mem_arbiter;

   localparam int T = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;

   // requesters
   bit          rq[2], infl[2], r_we[2];
   logic [31:0] r_addr[2], r_wd[2];

   // transaction model
   bit          t_act, t_err, t_we, m_last;
   int          t_own, t_g, t_dv, t_d, idle_at;
   logic [31:0] t_addr, t_wd, t_rd, t_ack;
   bit          e_we;
   logic [31:0] e_addr, e_wd, e_rd;

   // knobs
   int          ack_d = -1;          // forced ack delay, -1 = random
   bit          force_rd_en = 1'b0;
   logic [31:0] force_rd;
   int          spur_pct = 0, drop_pct = 0;
   bit          rnd_en = 1'b0;

   // observations for directed checks
   int          gcyc[2], dvcyc[2], nreq, t0;
   logic [31:0] dvrd[2];
   bit          dverr[2];

   task automatic ck1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic ck32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clr_obs();
      for (int p = 0; p < 2; p++) begin
         gcyc[p] = -1; dvcyc[p] = -1; dvrd[p] = 'x; dverr[p] = 1'b0;
      end
      nreq = 0;
   endtask

   task automatic raise(input int p, input logic [31:0] a, input bit we, input logic [31:0] wd);
      rq[p] = 1'b1; r_addr[p] = a; r_we[p] = we; r_wd[p] = wd;
   endtask

   task automatic check_cycle();
      bit g, v, busy;
      g    = t_act && cyc == t_g;
      v    = t_act && cyc == t_dv;
      busy = t_act && cyc >= t_g && cyc < t_dv;
      if (g) begin e_addr = t_addr; e_we = t_we; e_wd = t_wd; end
      if (v) e_rd = t_rd;
      ck1("grant_0", bus.grant_0, g && t_own == 0);
      ck1("grant_1", bus.grant_1, g && t_own == 1);
      ck1("data_valid_0", bus.data_valid_0, v && t_own == 0);
      ck1("data_valid_1", bus.data_valid_1, v && t_own == 1);
      ck1("err", bus.err, v && t_err);
      ck1("mem_req", bus.mem_req, busy);
      ck1("mem_we", bus.mem_we, e_we);
      ck32("mem_addr", bus.mem_addr, e_addr);
      ck32("mem_wrt_data", bus.mem_wrt_data, e_wd);
      ck32("rd_data", bus.rd_data, e_rd);
      if (bus.grant_0) gcyc[0] = cyc;
      if (bus.grant_1) gcyc[1] = cyc;
      if (bus.data_valid_0) begin dvcyc[0] = cyc; dvrd[0] = bus.rd_data; dverr[0] = bus.err; end
      if (bus.data_valid_1) begin dvcyc[1] = cyc; dvrd[1] = bus.rd_data; dverr[1] = bus.err; end
      if (bus.mem_req) nreq++;
      // requester sees its completion and lets go
      if (v) begin t_act = 1'b0; rq[t_own] = 1'b0; infl[t_own] = 1'b0; end
   endtask

   task automatic rand_reqs();
      for (int p = 0; p < 2; p++) begin
         if (!rq[p] && !infl[p] && $urandom_range(0, 99) < 35)
            raise(p, $urandom, 1'($urandom_range(0, 1)), $urandom);
         else if (!rq[p]) begin
            // idle port fields wander; must not reach the memory port
            r_addr[p] = $urandom; r_we[p] = 1'($urandom_range(0, 1)); r_wd[p] = $urandom;
         end else if (infl[p] && t_act && t_own == p && cyc >= t_g
                      && $urandom_range(0, 99) < drop_pct)
            rq[p] = 1'b0;
      end
   endtask

   task automatic arb_model();
      int w;
      if (!t_act && cyc >= idle_at && (rq[0] || rq[1])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         w = (rq[0] && rq[1]) ? (m_last ? 0 : 1) : (rq[1] ? 1 : 0);
`else
         w = rq[1] ? 1 : 0;
`endif
         m_last  = (w == 1);
         t_act   = 1'b1;
         t_own   = w;
         t_g     = cyc + 1;
         t_d     = (ack_d >= 0) ? ack_d : int'($urandom_range(0, T + 1));
         t_dv    = t_g + ((t_d + 1 < T) ? t_d + 1 : T);
         t_err   = (t_d >= T);
         t_addr  = r_addr[w]; t_we = r_we[w]; t_wd = r_wd[w];
         t_ack   = force_rd_en ? force_rd : $urandom;
         t_rd    = (t_we || t_err) ? 32'h0 : t_ack;
         idle_at = t_dv + 1;
         infl[w] = 1'b1;
      end
   endtask

   task automatic tick(input bit rst_now = 1'b0);
      check_cycle();
      if (rnd_en) rand_reqs();
      if (rst_now) begin
         for (int p = 0; p < 2; p++) begin rq[p] = 1'b0; infl[p] = 1'b0; end
         t_act = 1'b0; m_last = 1'b1; idle_at = cyc + 1;
         e_addr = '0; e_we = 1'b0; e_wd = '0; e_rd = '0;
      end else
         arb_model();
      reset = rst_now;
      bus.mem_ack     = 1'b0;
      bus.mem_rd_data = $urandom;
      if (t_act && !t_err && cyc == t_g + t_d) begin
         bus.mem_ack = 1'b1; bus.mem_rd_data = t_ack;
      end else if (!(t_act && cyc >= t_g) && $urandom_range(0, 99) < spur_pct)
         bus.mem_ack = 1'b1;
      bus.req_valid_0 = rq[0]; bus.addr_0 = r_addr[0]; bus.we_0 = r_we[0]; bus.wrt_data_0 = r_wd[0];
      bus.req_valid_1 = rq[1]; bus.addr_1 = r_addr[1]; bus.we_1 = r_we[1]; bus.wrt_data_1 = r_wd[1];
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      int first;
      reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
         rq[p] = 1'b0; infl[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
      end
      bus.req_valid_0 = 1'b0; bus.addr_0 = '0; bus.we_0 = 1'b0; bus.wrt_data_0 = '0;
      bus.req_valid_1 = 1'b0; bus.addr_1 = '0; bus.we_1 = 1'b0; bus.wrt_data_1 = '0;
      bus.mem_ack = 1'b0; bus.mem_rd_data = '0;
      repeat (2) @(posedge clk);
      #1;
      t_act = 1'b0; m_last = 1'b1; idle_at = cyc;
      e_addr = '0; e_we = 1'b0; e_wd = '0; e_rd = '0;
      clr_obs();
      tick(); tick();                       // reset state: everything 0

      // port 0 read, ack two cycles after grant
      clr_obs(); t0 = cyc; ack_d = 2; force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
      raise(0, 32'h100, 1'b0, 32'h0);
      repeat (7) tick();
      ck32("r029_grant_cyc", gcyc[0] - t0, 1);
      ck32("r029_dv_cyc", dvcyc[0] - t0, 4);
      ck32("r029_rd", dvrd[0], 32'hDEADBEEF);
      ck32("r029_p1_grant", gcyc[1], -1);
      ck32("r029_p1_dv", dvcyc[1], -1);

      // simultaneous requests straight after reset
      tick(1'b1);
      clr_obs(); t0 = cyc; ack_d = 0; force_rd_en = 1'b0;
      raise(0, 32'h200, 1'b0, 32'h0);
      raise(1, 32'h300, 1'b0, 32'h0);
      repeat (9) tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first = 0;
`else
      first = 1;
`endif
      ck32("r030_first_grant", gcyc[first] - t0, 1);
      ck32("r030_second_grant", gcyc[1 - first] - t0, 4);

      // port 1 store
      clr_obs(); t0 = cyc; ack_d = 1;
      raise(1, 32'h40, 1'b1, 32'h12345678);
      repeat (6) tick();
      ck32("r031_dv_cyc", dvcyc[1] - t0, 3);
      ck32("r031_rd", dvrd[1], 32'h0);
      ck32("r031_memreq_cycles", nreq, 2);

      // timeout with no ack
      clr_obs(); t0 = cyc; ack_d = 99;
      raise(0, 32'h500, 1'b0, 32'h0);
      repeat (8) tick();
      ck32("r032_memreq_cycles", nreq, T);
      ck32("r032_dv_cyc", dvcyc[0] - t0, T + 1);
      ck1("r032_err", dverr[0], 1'b1);
      ck32("r032_rd", dvrd[0], 32'h0);

      // reset during the second BUSY cycle drops the transaction
      clr_obs(); t0 = cyc; ack_d = 3;
      raise(1, 32'h600, 1'b0, 32'h0);
      tick(); tick(); tick(1'b1);
      repeat (6) tick();
      ck32("r033_no_dv", dvcyc[1], -1);
      clr_obs(); t0 = cyc; ack_d = 0;
      raise(1, 32'h700, 1'b0, 32'h0);
      repeat (5) tick();
      ck32("r033_after_dv_cyc", dvcyc[1] - t0, 2);

      // stray acks in IDLE/RESP, ack coincident with timeout
      clr_obs(); t0 = cyc; ack_d = T - 1; spur_pct = 100;
      force_rd_en = 1'b1; force_rd = 32'hCAFEF00D;
      tick(); tick();
      t0 = cyc;
      raise(0, 32'h800, 1'b0, 32'h0);
      repeat (8) tick();
      ck32("r034_dv_cyc", dvcyc[0] - t0, T + 1);
      ck1("r034_err", dverr[0], 1'b0);
      ck32("r034_rd", dvrd[0], 32'hCAFEF00D);

      // randomized traffic
      ack_d = -1; force_rd_en = 1'b0; spur_pct = 20; drop_pct = 10; rnd_en = 1'b1;
      repeat (3000) tick($urandom_range(0, 299) == 0);
      rnd_en = 1'b0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
